// File: rtl/alu_result_buffer.sv
// Result buffer behind the 4-bit ALU: forms {result, opcode, zero/neg/err flags} per push
// and queues them in a first-word-fall-through FIFO with valid/ready on both sides.
// Optional saturating divide-by-zero counter enabled by defining ALU_RESULT_ERRCNT_EN.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [2:0]       s,
  input  logic [7:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_err,
  output logic [PTR_W:0]   count
`ifdef ALU_RESULT_ERRCNT_EN
  ,
  input  logic             err_clr,
  output logic [7:0]       err_count
`endif
);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] op;
    logic       zero;
    logic       neg;
    logic       err;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           entry_d;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  // Operand a does not affect the stored entry; it is only part of the ALU-side bundle.
  logic unused_a;
  assign unused_a = ^a;

  // Handshake flags come from registered occupancy only.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    entry_d      = '0;
    entry_d.op   = s;
    entry_d.err  = ((s == 3'b011) || (s == 3'b110)) && (b == 4'h0);
    if (!entry_d.err) begin
      entry_d.data = y;
      entry_d.zero = (y == 8'h00);
      entry_d.neg  = y[7];
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_data  = head.data;
  assign out_op    = head.op;
  assign out_zero  = head.zero;
  assign out_neg   = head.neg;
  assign out_err   = head.err;

`ifdef ALU_RESULT_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Clear wins over increment; the count sticks at 8'hFF.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (push && entry_d.err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 4-bit combinational ALU (operands a/b, 3-bit opcode s, 8-bit result y).
- Captures each issued ALU result with its opcode and derives status flags (zero, sign, divide-by-zero error).
- Buffers entries in a small first-word-fall-through FIFO and presents them to the consumer with a valid/ready handshake.
- Decouples the combinational ALU from a slower downstream writeback or display stage.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  ALU result on y is valid this cycle.
- in_ready  output  1  buffer can accept an entry (not full).
- a  input  4  ALU operand a, as applied to the ALU this cycle.
- b  input  4  ALU operand b, as applied to the ALU this cycle.
- s  input  3  ALU opcode, as applied to the ALU this cycle.
- y  input  8  ALU result.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  8  head entry result.
- out_op  output  3  head entry opcode.
- out_zero  output  1  head entry result equals 8'h00 (always 0 when out_err=1).
- out_neg  output  1  head entry result bit 7.
- out_err  output  1  head entry was a divide-by-zero or modulo-by-zero.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Read pointer, write pointer and count go to 0.
  - out_valid=0, in_ready=1.
  - out_data, out_op, out_zero, out_neg and out_err read 0 while empty.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries the same edge; any push or pop in that cycle is ignored.
- in_ready = (count != DEPTH). out_valid = (count != 0). Both decode combinationally from registered count only, with no combinational path from in_valid or out_ready.
- Push occurs when in_valid && in_ready at the rising edge. The entry is written at the write pointer, which then increments modulo DEPTH.
- Pop occurs when out_valid && out_ready at the rising edge. The read pointer increments modulo DEPTH.
- Entry formation at push:
  - err = (s==3'b011 || s==3'b110) && (b==4'h0).
  - If err=1: data is forced to 8'h00, zero=0, neg=0.
  - Otherwise: data = y, zero = (y==8'h00), neg = y[7].
  - op = s in both cases.
- Latency: an entry pushed at edge N appears at the outputs with out_valid=1 after edge N, when the buffer was empty.
- Head outputs are first-word-fall-through: they show storage[rd_ptr] while out_valid=1, and are held stable until popped.
- Simultaneous push and pop (0 < count < DEPTH): both occur and count is unchanged.
- Full (count==DEPTH): in_ready=0, so no push occurs even if a pop happens in the same cycle. in_ready rises the cycle after the pop.
- Empty: no pop occurs (out_valid=0). A push sets count to 1.
- Pointers wrap from DEPTH-1 to 0.
- in_valid while in_ready=0 is dropped. The producer must hold until in_ready=1.
- count updates: +1 on push only, -1 on pop only, otherwise unchanged.

Optional Feature:
- Macro: ALU_RESULT_ERRCNT_EN.
- When defined:
  - Adds output err_count [7:0], a saturating count of pushed entries with err=1.
  - Resets to 0, increments on each such push and saturates at 8'hFF.
  - Adds input err_clr (1 bit); err_clr=1 at an edge clears the count to 0, and clear takes priority over increment.
- When not defined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> out_valid=0, in_ready=1, count=0, out_data=8'h00.
- Single push/pop: a=4'h3, b=4'h5, s=3'b000, y=8'h08, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=8'h08, out_op=0, out_zero=0, out_neg=0; popped the following edge, count returns to 0.
- Divide-by-zero: s=3'b011, b=0, y=8'hXX pushed -> out_err=1, out_data=8'h00, out_zero=0. Also s=3'b110, b=0 -> out_err=1. With ALU_RESULT_ERRCNT_EN defined, err_count=2.
- Fill and backpressure: out_ready=0, push 5 results 8'h01..8'h05 back-to-back -> first 4 accepted, count=4, in_ready=0, 5th held. Raise out_ready -> outputs drain 01,02,03,04 in order, and 8'h05 is accepted the cycle after in_ready rises.
- Simultaneous push/pop at count=2 -> count stays 2; order preserved across pointer wrap over 10 continuous transfers.
- Reset mid-stream: count=3, assert rst_n=0 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and no entry is retained.
